// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART transmit scheduler.
//   sched_state_t : scheduler FSM state encoding
//   DEFAULT_*     : default parameter values for the scheduler
//   max_int       : constant helper used to size the shared timer
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        CAPTURE   = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } sched_state_t;

    localparam int DEFAULT_DATA_BITS      = 8;
    localparam int DEFAULT_GAP_CYCLES     = 0;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
    localparam int DEFAULT_COUNT_BITS     = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the FIFO-side, transmitter-side and status signals of the
// transmit scheduler.
//   master : the scheduler (drives pop request, start, data, status)
//   slave  : the environment (FIFO + transmitter + control)
// Signals:
//   enable, fifo_isEmpty, fifo_dequeue, tx_busy, tx_done  (to scheduler)
//   fifo_req_dequeue, tx_start, tx_data, busy,
//   frame_count, timeout_err                             (from scheduler)
// ---------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int DATA_BITS  = 8,
    parameter int COUNT_BITS = 16
);
    logic                  enable;
    logic                  fifo_isEmpty;
    logic [DATA_BITS-1:0]  fifo_dequeue;
    logic                  fifo_req_dequeue;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_start;
    logic [DATA_BITS-1:0]  tx_data;
    logic                  busy;
    logic [COUNT_BITS-1:0] frame_count;
    logic                  timeout_err;

    modport master (
        input  enable, fifo_isEmpty, fifo_dequeue, tx_busy, tx_done,
        output fifo_req_dequeue, tx_start, tx_data, busy, frame_count, timeout_err
    );

    modport slave (
        output enable, fifo_isEmpty, fifo_dequeue, tx_busy, tx_done,
        input  fifo_req_dequeue, tx_start, tx_data, busy, frame_count, timeout_err
    );
endinterface

// File: rtl/sched_timer.sv
// ---------------------------------------------------------------------------
// sched_timer
// Loadable up-counter with a terminal-count flag. Shared between the
// inter-frame gap and the tx_done watchdog, which never run together.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : clear the count to zero (has priority over inc)
//   inc        : advance the count by one
//   terminal   : value at which tc asserts
//   tc         : count equals terminal
// ---------------------------------------------------------------------------
module sched_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == terminal);

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Pulls bytes from the TX FIFO one at a time and hands each to the UART
// transmitter: pop -> capture -> start -> wait for done (with watchdog)
// -> optional idle gap -> back to idle.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : uart_tx_scheduler_if.master (FIFO, transmitter, status)
// All outputs come straight from flops; they are computed from the next
// state so they are aligned with the state they describe.
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int COUNT_BITS     = DEFAULT_COUNT_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_scheduler_if.master     bus
);
    localparam int TIMER_W = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    // GAP lasts GAP_CYCLES clocks; the watchdog fires on the clock where the
    // count reaches TIMEOUT_CYCLES-1. Both counts start at zero.
    localparam logic [TIMER_W-1:0] GAP_TERM =
        TIMER_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TIMER_W-1:0] TIMEOUT_TERM =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    sched_state_t          state_q, state_d;
    logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
    logic [COUNT_BITS-1:0] frame_count_q, frame_count_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  fifo_req_q, fifo_req_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;

    logic                  timer_load;
    logic                  timer_inc;
    logic                  timer_tc;
    logic [TIMER_W-1:0]    timer_terminal;

    assign timer_terminal = (state_q == GAP) ? GAP_TERM : TIMEOUT_TERM;

    sched_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .inc      (timer_inc),
        .terminal (timer_terminal),
        .tc       (timer_tc)
    );

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        frame_count_d = frame_count_q;
        timeout_err_d = timeout_err_q;
        timer_load    = 1'b0;
        timer_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                // FIFO level and transmitter activity only matter here.
                if (bus.enable && !bus.fifo_isEmpty && !bus.tx_busy) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // FIFO read data is valid one cycle after the pop request.
                tx_data_d = bus.fifo_dequeue;
                state_d   = START;
            end
            START: begin
                timer_load = 1'b1;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done is checked first so it wins over a same-cycle expiry.
                if (bus.tx_done) begin
                    frame_count_d = frame_count_q + COUNT_BITS'(1);
                    if (GAP_CYCLES > 0) begin
                        timer_load = 1'b1;
                        state_d    = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timer_tc) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            GAP: begin
                if (timer_tc) begin
                    state_d = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fifo_req_d = (state_d == POP);
        tx_start_d = (state_d == START);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
            fifo_req_q    <= 1'b0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            frame_count_q <= frame_count_d;
            timeout_err_q <= timeout_err_d;
            fifo_req_q    <= fifo_req_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.fifo_req_dequeue = fifo_req_q;
    assign bus.tx_start         = tx_start_q;
    assign bus.tx_data          = tx_data_q;
    assign bus.busy             = busy_q;
    assign bus.frame_count      = frame_count_q;
    assign bus.timeout_err      = timeout_err_q;

endmodule
